// File: rtl/bmf_h_stream_decoder_if.sv
// Stream/config bus for bmf_h_stream_decoder: H-row programming port,
// latent-vector input handshake, reconstructed-output handshake and counters.
interface bmf_h_stream_decoder_if #(
  parameter int unsigned K     = 6,
  parameter int unsigned M     = 7,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned ROW_W = (M > 1) ? $clog2(M) : 1;

  logic             cfg_we;
  logic [ROW_W-1:0] cfg_row;
  logic [K-1:0]     cfg_data;
  logic             cfg_xor;

  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     in_k;
  logic [M-1:0]     in_exp;

  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_po;

  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] err_cnt;

  // Source / sink side (latent-vector producer plus output consumer)
  modport master (
    output cfg_we, cfg_row, cfg_data, cfg_xor,
    output in_valid, in_k, in_exp, out_ready,
    input  in_ready, out_valid, out_po, beat_cnt, err_cnt
  );

  // Decoder side
  modport slave (
    input  cfg_we, cfg_row, cfg_data, cfg_xor,
    input  in_valid, in_k, in_exp, out_ready,
    output in_ready, out_valid, out_po, beat_cnt, err_cnt
  );
endinterface

// File: rtl/bmf_h_stream_decoder.sv
// Streaming BMF decompressor: K-bit latent beats -> M outputs through a
// programmable factor matrix H (per-row OR/XOR). Optional BMF_ERRCNT_EN adds err_cnt.
module bmf_h_stream_decoder #(
  parameter int unsigned K     = 6,
  parameter int unsigned M     = 7,
  parameter int unsigned CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  bmf_h_stream_decoder_if.slave  bus
);

  localparam int unsigned POP_W = $clog2(M + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Factor matrix: one K-bit mask plus one combine-mode bit per output row
  logic [K-1:0]     h_mask_q [M];
  logic [K-1:0]     h_mask_d [M];
  logic [M-1:0]     h_xor_q;
  logic [M-1:0]     h_xor_d;

  logic             s1_v_q;
  logic             s1_v_d;
  logic [K-1:0]     s1_k_q;
  logic [K-1:0]     s1_k_d;

  logic             out_valid_q;
  logic             out_valid_d;
  logic [M-1:0]     out_po_q;
  logic [M-1:0]     out_po_d;

  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;

  logic             s2_free_c;
  logic             s1_adv_c;
  logic             accept_c;
  logic             deliver_c;
  logic             cfg_hit_c;
  logic [M-1:0]     decode_c;

  // Handshake terms
  always_comb begin
    s2_free_c = !out_valid_q || bus.out_ready;
    s1_adv_c  = s1_v_q && s2_free_c;
    accept_c  = bus.in_valid && (!s1_v_q || s2_free_c);
    deliver_c = out_valid_q && bus.out_ready;
    cfg_hit_c = bus.cfg_we && (32'(bus.cfg_row) < M);
  end

  // Row decode reads the registered H, so a same-edge config write is not seen
  always_comb begin
    logic [K-1:0] masked;
    masked   = '0;
    decode_c = '0;
    for (int unsigned j = 0; j < M; j++) begin
      masked      = s1_k_q & h_mask_q[j];
      decode_c[j] = h_xor_q[j] ? (^masked) : (|masked);
    end
  end

  always_comb begin
    h_mask_d = h_mask_q;
    h_xor_d  = h_xor_q;
    if (cfg_hit_c) begin
      h_mask_d[bus.cfg_row] = bus.cfg_data;
      h_xor_d[bus.cfg_row]  = bus.cfg_xor;
    end
  end

  // Two-stage pipeline with saturating delivered-beat counter
  always_comb begin
    s1_v_d      = s1_v_q;
    s1_k_d      = s1_k_q;
    out_valid_d = out_valid_q;
    out_po_d    = out_po_q;
    beat_cnt_d  = beat_cnt_q;

    if (accept_c) begin
      s1_v_d = 1'b1;
      s1_k_d = bus.in_k;
    end else if (s1_adv_c) begin
      s1_v_d = 1'b0;
    end

    if (s1_adv_c) begin
      out_valid_d = 1'b1;
      out_po_d    = decode_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (deliver_c && (beat_cnt_q != {CNT_W{1'b1}})) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < M; j++) begin
        h_mask_q[j] <= K'(1) << (j % K);
      end
      h_xor_q     <= '0;
      s1_v_q      <= 1'b0;
      s1_k_q      <= '0;
      out_valid_q <= 1'b0;
      out_po_q    <= '0;
      beat_cnt_q  <= '0;
    end else begin
      h_mask_q    <= h_mask_d;
      h_xor_q     <= h_xor_d;
      s1_v_q      <= s1_v_d;
      s1_k_q      <= s1_k_d;
      out_valid_q <= out_valid_d;
      out_po_q    <= out_po_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign bus.in_ready  = !s1_v_q || s2_free_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_po    = out_po_q;
  assign bus.beat_cnt  = beat_cnt_q;

`ifdef BMF_ERRCNT_EN
  // Reference outputs travel with their beat; mismatching bits accumulate on delivery
  logic [M-1:0]     s1_exp_q;
  logic [M-1:0]     s1_exp_d;
  logic [M-1:0]     s2_exp_q;
  logic [M-1:0]     s2_exp_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [POP_W-1:0] err_bits_c;
  logic [SUM_W-1:0] err_sum_c;

  always_comb begin
    s1_exp_d   = accept_c ? bus.in_exp : s1_exp_q;
    s2_exp_d   = s1_adv_c ? s1_exp_q : s2_exp_q;
    err_bits_c = '0;
    for (int unsigned j = 0; j < M; j++) begin
      err_bits_c = err_bits_c + POP_W'(out_po_q[j] ^ s2_exp_q[j]);
    end
    err_sum_c = SUM_W'(err_cnt_q) + SUM_W'(err_bits_c);
    err_cnt_d = err_cnt_q;
    if (deliver_c) begin
      err_cnt_d = err_sum_c[CNT_W] ? {CNT_W{1'b1}} : err_sum_c[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_exp_q  <= '0;
      s2_exp_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      s1_exp_q  <= s1_exp_d;
      s2_exp_q  <= s2_exp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_exp;
  logic unused_sum_w;
  assign unused_exp   = ^bus.in_exp;
  assign unused_sum_w = (SUM_W > POP_W);
  assign bus.err_cnt  = '0;
`endif

endmodule

// File: doc/bmf_h_stream_decoder.md
Name: bmf_h_stream_decoder

Overview:
- Streaming Boolean-matrix-factorization decompressor. Accepts K-bit latent vectors from a BMF compressor partition and reconstructs M approximate primary outputs through a run-time programmable factor matrix H.
- Each output row combines its selected latent bits with either OR (Boolean semiring) or XOR (GF(2)), selected per row.
- Sits at the receiving end of a partition link, after a latent-vector source. Used for on-chip evaluation of factorization candidates without resynthesis.

Parameters:
- K, 6, latent width (number of k signals); legal range 1..16
- M, 7, reconstructed output width (number of po signals); legal range 1..32
- CNT_W, 16, width of beat and error counters

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- cfg_we  input  1  write-enable for one H row
- cfg_row  input  $clog2(M)  row (output index) being written
- cfg_data  input  K  row mask; bit i set means k_i contributes to po_row
- cfg_xor  input  1  row combine mode: 1 = XOR, 0 = OR
- in_valid  input  1  latent beat valid
- in_ready  output  1  decoder can accept a beat
- in_k  input  K  latent vector
- in_exp  input  M  exact reference outputs for this beat (used only by the optional feature)
- out_valid  output  1  reconstructed beat valid
- out_ready  input  1  downstream accepts
- out_po  output  M  reconstructed outputs
- beat_cnt  output  CNT_W  beats delivered (out_valid & out_ready), saturating
- err_cnt  output  CNT_W  mismatching output bits, saturating (optional feature)

Behaviour:
- Storage: H is M rows of K bits plus one mode bit per row.
- Reset values:
  - H row j = one-hot at bit (j mod K); all modes OR.
  - S1 and S2 valid flags = 0; out_valid = 0; out_po = 0.
  - beat_cnt = 0; err_cnt = 0.
  - in_ready = 1 in the first cycle after reset.
- Config:
  - When cfg_we = 1 and cfg_row < M, the row mask and mode are written at the clock edge.
  - cfg_row >= M: write ignored.
  - Config writes are allowed at any time, including mid-stream.
- Pipeline: two stages, latency 2 cycles from input accept to out_valid.
  - S1 registers in_k and in_exp on in_valid & in_ready.
  - S2 (the output register) holds po_j computed from S1 contents and the current H:
    - OR mode: po_j = OR over i of (k_i & H[j][i]).
    - XOR mode: po_j = XOR over i of (k_i & H[j][i]).
    - An all-zero row gives po_j = 0 in both modes.
- Flow control:
  - s2_free = !out_valid | out_ready.
  - S1 advances to S2 when S1 is valid and s2_free.
  - in_ready = !s1_v | s2_free (combinational, no skid buffer).
  - Full throughput: one beat per cycle when out_ready is held high.
- Stall rules:
  - While out_valid = 1 and out_ready = 0, out_po holds stable.
  - No beat is dropped or duplicated.
- Config versus data on the same edge:
  - A beat that moves S1 to S2 on the same edge as a cfg write is decoded with the old H.
  - Every beat already held in S2 keeps the value it was computed with.
- Counters:
  - beat_cnt increments on each out_valid & out_ready.
  - It saturates at all-ones and does not wrap.
- Reset mid-operation: all in-flight beats are discarded, H returns to its default, and the counters clear.

Optional Feature:
- Macro: BMF_ERRCNT_EN.
- Defined:
  - When a beat moves S1 to S2, its in_exp value is carried alongside.
  - On delivery (out_valid & out_ready), err_cnt adds popcount(out_po ^ carried exp).
  - The add saturates at all-ones.
- Not defined:
  - err_cnt is tied to 0.
  - in_exp is ignored and no exp storage is synthesized.

Test Plan:
- Reset defaults, K=6, M=7:
  - Stimulus: rst for 2 cycles, then in_k = 6'b101101 with out_ready = 1.
  - Response: out_valid exactly 2 cycles after accept; out_po = 7'b1101101 (po6 = k0).
  - After delivery, beat_cnt = 1.
- XOR row:
  - Stimulus: write row 0 with mask 6'b000011 and cfg_xor = 1; send k = 6'b000001, then k = 6'b000011.
  - Response: po0 = 1 for the first beat, po0 = 0 for the second.
  - Repeat with OR mode: po0 = 1 for both beats.
- Backpressure:
  - Stimulus: stream 4 beats with out_ready low for cycles 3 to 6.
  - Response: in_ready drops once S1 and S2 are both full; out_po stays stable while stalled.
  - All 4 beats arrive in order and beat_cnt = 4.
- Same-edge config:
  - Stimulus: write row 1 to all-zero on the same edge as a transfer of k = 6'b111111.
  - Response: that beat has po1 = 1; the next identical beat has po1 = 0.
- Reset mid-stream:
  - Stimulus: assert rst while S1 and S2 are valid.
  - Response: next cycle out_valid = 0 and counters = 0; H returns to its default mapping.
- Error count (BMF_ERRCNT_EN defined):
  - Stimulus: default H, in_k = 6'b000000, in_exp = 7'b0000101; deliver the beat.
  - Response: err_cnt = 2.
  - With the macro undefined, err_cnt stays 0.
